async_fifo: RTL and testbench

Dual-clock FIFO that carries DSIZE-bit words between a write domain (wclk) and the Hyperbus domain (hbus_clk, read side). It uses the classic gray-coded pointer scheme with two-flop synchronizers and first-word-fall-through read data. It is instantiated by the Hyperbus FIFO bridge for command, TX and RX queues.

---
 rtl/async_fifo_pkg.sv | 23 ++
 rtl/async_fifo_sync.sv | 26 ++
 rtl/async_fifo.sv | 110 +++++++++++
 tb/tb_async_fifo.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared pointer helpers and constants for the dual-clock FIFO.
package async_fifo_pkg;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned PTR_MAX     = 13;

  typedef logic [PTR_MAX-1:0] gptr_t;

  function automatic gptr_t bin2gray(input gptr_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Narrower pointers are zero-extended, so the fold from the MSB stays exact.
  function automatic gptr_t gray2bin(input gptr_t gray);
    gptr_t bin;
    bin[PTR_MAX-1] = gray[PTR_MAX-1];
    for (int unsigned i = PTR_MAX - 1; i > 0; i--) begin
      bin[i-1] = bin[i] ^ gray[i-1];
    end
    return bin;
  endfunction

endpackage

// File: rtl/async_fifo_sync.sv
// Multi-flop synchronizer for a gray-coded pointer, asynchronously cleared.
module async_fifo_sync
  import async_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/async_fifo.sv
// Dual-clock FWFT FIFO (wclk -> hbus_clk) with gray-pointer crossing.
// Define ASYNC_FIFO_ERR_EN to add sticky overflow/underflow outputs wovf/rudf.
module async_fifo
  import async_fifo_pkg::*;
#(
  parameter int unsigned DSIZE = 32,
  parameter int unsigned ASIZE = 2
) (
  input  logic             hbus_clk,
  input  logic             hbus_rst,
  input  logic             wclk,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             awfull,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             arempty
`ifdef ASYNC_FIFO_ERR_EN
  ,
  output logic             wovf,
  output logic             rudf
`endif
);

  localparam int unsigned PW    = ASIZE + 1;
  localparam int unsigned DEPTH = 1 << ASIZE;
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);
  localparam logic [PW-1:0] DEPTH_M1  = PW'(DEPTH - 1);

  logic [DSIZE-1:0] mem [DEPTH];

  logic [PW-1:0] wbin, wgray, wbin_next, wgray_next, rgray_s, rbin_s;
  logic [PW-1:0] rbin, rgray, rbin_next, rgray_next, wgray_s, wbin_s;
  logic          w_push, r_pop;

  // ---------------- write domain ----------------
  assign w_push     = winc && !wfull;
  assign wbin_next  = wbin + PW'(w_push);
  assign wgray_next = PW'(bin2gray(gptr_t'(wbin_next)));
  assign rbin_s     = PW'(gray2bin(gptr_t'(rgray_s)));

  always_ff @(posedge wclk or posedge hbus_rst) begin
    if (hbus_rst) begin
      wbin   <= '0;
      wgray  <= '0;
      wfull  <= 1'b0;
      awfull <= 1'b0;
    end else begin
      wbin   <= wbin_next;
      wgray  <= wgray_next;
      wfull  <= (wgray_next == (rgray_s ^ FULL_MASK));
      awfull <= ((wbin_next - rbin_s) >= DEPTH_M1);
    end
  end

  always_ff @(posedge wclk) begin
    if (w_push) mem[wbin[ASIZE-1:0]] <= wdata;
  end

  // ---------------- read domain ----------------
  assign r_pop      = rinc && !rempty;
  assign rbin_next  = rbin + PW'(r_pop);
  assign rgray_next = PW'(bin2gray(gptr_t'(rbin_next)));
  assign wbin_s     = PW'(gray2bin(gptr_t'(wgray_s)));
  assign rdata      = mem[rbin[ASIZE-1:0]];

  always_ff @(posedge hbus_clk or posedge hbus_rst) begin
    if (hbus_rst) begin
      rbin    <= '0;
      rgray   <= '0;
      rempty  <= 1'b1;
      arempty <= 1'b1;
    end else begin
      rbin    <= rbin_next;
      rgray   <= rgray_next;
      rempty  <= (rgray_next == wgray_s);
      arempty <= ((wbin_s - rbin_next) <= PW'(1));
    end
  end

  // ---------------- pointer crossings ----------------
  async_fifo_sync #(.WIDTH(PW)) u_w2r_sync (
    .clk (hbus_clk),
    .clr (hbus_rst),
    .d   (wgray),
    .q   (wgray_s)
  );

  async_fifo_sync #(.WIDTH(PW)) u_r2w_sync (
    .clk (wclk),
    .clr (hbus_rst),
    .d   (rgray),
    .q   (rgray_s)
  );

`ifdef ASYNC_FIFO_ERR_EN
  always_ff @(posedge wclk or posedge hbus_rst) begin
    if (hbus_rst)           wovf <= 1'b0;
    else if (winc && wfull) wovf <= 1'b1;
  end

  always_ff @(posedge hbus_clk or posedge hbus_rst) begin
    if (hbus_rst)            rudf <= 1'b0;
    else if (rinc && rempty) rudf <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_async_fifo.sv
// Directed bench for async_fifo (DSIZE=33, ASIZE=2) with unrelated 10 ns / 7 ns clocks.
`timescale 1ns/100ps
module tb_async_fifo;

  localparam int unsigned DSIZE = 33;
  localparam int unsigned ASIZE = 2;

  logic             hbus_clk = 1'b0;
  logic             hbus_rst = 1'b1;
  logic             wclk     = 1'b0;
  logic             winc     = 1'b0;
  logic             rinc     = 1'b0;
  logic [DSIZE-1:0] wdata    = '0;
  logic [DSIZE-1:0] rdata;
  logic             wfull, awfull, rempty, arempty;
`ifdef ASYNC_FIFO_ERR_EN
  logic             wovf, rudf;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [DSIZE-1:0] q [$];
  int got = 0;

  async_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
    .hbus_clk (hbus_clk),
    .hbus_rst (hbus_rst),
    .wclk     (wclk),
    .winc     (winc),
    .wdata    (wdata),
    .wfull    (wfull),
    .awfull   (awfull),
    .rinc     (rinc),
    .rdata    (rdata),
    .rempty   (rempty),
    .arempty  (arempty)
`ifdef ASYNC_FIFO_ERR_EN
    ,
    .wovf     (wovf),
    .rudf     (rudf)
`endif
  );

  initial forever #5 wclk = ~wclk;
  initial begin
    #2;
    forever #3.5 hbus_clk = ~hbus_clk;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [DSIZE-1:0] d);
    @(negedge wclk);
    wdata = d;
    winc  = 1'b1;
    @(negedge wclk);
    winc  = 1'b0;
  endtask

  task automatic wait_not_empty(input string tag);
    int n = 0;
    while (rempty === 1'b1 && n < 20) begin
      @(negedge hbus_clk);
      n++;
    end
    check(tag, 64'(rempty), 64'd0);
  endtask

  task automatic pop_expect(input string tag, input logic [DSIZE-1:0] exp);
    @(negedge hbus_clk);
    check(tag, 64'(rdata), 64'(exp));
    rinc = 1'b1;
    @(negedge hbus_clk);
    rinc = 1'b0;
  endtask

  initial begin
    int edges;

    // Reset
    repeat (3) @(negedge wclk);
    check("rst_rempty",  64'(rempty),  64'd1);
    check("rst_arempty", 64'(arempty), 64'd1);
    check("rst_wfull",   64'(wfull),   64'd0);
    check("rst_awfull",  64'(awfull),  64'd0);
`ifdef ASYNC_FIFO_ERR_EN
    check("rst_wovf", 64'(wovf), 64'd0);
    check("rst_rudf", 64'(rudf), 64'd0);
`endif
    hbus_rst = 1'b0;
    repeat (3) @(negedge wclk);

    // Single word: visible within 3 read edges, FWFT data, then empty again
    @(negedge wclk);
    wdata = 33'h1_0000_1000;
    winc  = 1'b1;
    @(posedge wclk);
    fork
      begin #1 winc = 1'b0; end
    join_none
    edges = 0;
    while (rempty === 1'b1 && edges < 3) begin
      @(posedge hbus_clk);
      #1;
      edges++;
    end
    check("first_visible", 64'(rempty), 64'd0);
    check("fwft_rdata",    64'(rdata),  64'h1_0000_1000);
    pop_expect("first_pop", 33'h1_0000_1000);
    check("empty_after_pop", 64'(rempty), 64'd1);
    repeat (5) @(negedge wclk);

    // Fill to full, drop the overflow write
    write_word(33'hA);
    check("awfull_after_1", 64'(awfull), 64'd0);
    write_word(33'hB);
    check("awfull_after_2", 64'(awfull), 64'd0);
    write_word(33'hC);
    check("awfull_after_3", 64'(awfull), 64'd1);
    check("wfull_after_3",  64'(wfull),  64'd0);
    write_word(33'hD);
    check("wfull_after_4",  64'(wfull),  64'd1);
    write_word(33'hE);
    check("wfull_after_ovf", 64'(wfull), 64'd1);
    repeat (6) @(negedge hbus_clk);
    check("full_rempty",  64'(rempty),  64'd0);
    check("full_arempty", 64'(arempty), 64'd0);
    pop_expect("read_A", 33'hA);
    pop_expect("read_B", 33'hB);
    pop_expect("read_C", 33'hC);
    check("one_left_arempty", 64'(arempty), 64'd1);
    check("one_left_rempty",  64'(rempty),  64'd0);
    pop_expect("read_D", 33'hD);
    check("drained_rempty", 64'(rempty), 64'd1);
    repeat (6) @(negedge hbus_clk);
    check("no_E_rempty", 64'(rempty), 64'd1);
    repeat (5) @(negedge wclk);
    check("freed_wfull",  64'(wfull),  64'd0);
    check("freed_awfull", 64'(awfull), 64'd0);

    // Random streaming across many pointer wraps
    fork
      begin
        int sent = 0;
        int cyc  = 0;
        logic [DSIZE-1:0] d;
        while (sent < 1000 && cyc < 8000) begin
          @(negedge wclk);
          cyc++;
          if (!wfull && $urandom_range(0, 1) == 1) begin
            d     = {1'($urandom), 32'($urandom)};
            wdata = d;
            winc  = 1'b1;
            q.push_back(d);
            sent++;
          end else begin
            winc = 1'b0;
          end
        end
        @(negedge wclk);
        winc = 1'b0;
      end
      begin
        int cyc = 0;
        logic [DSIZE-1:0] e;
        while (got < 1000 && cyc < 12000) begin
          @(negedge hbus_clk);
          cyc++;
          if (!rempty && $urandom_range(0, 2) != 0) begin
            if (q.size() > 0) begin
              e = q.pop_front();
              check("stream_data", 64'(rdata), 64'(e));
            end else begin
              check("stream_underflow", 64'(q.size()), 64'd1);
            end
            rinc = 1'b1;
            got++;
          end else begin
            rinc = 1'b0;
          end
        end
        @(negedge hbus_clk);
        rinc = 1'b0;
      end
    join
    check("stream_count", 64'(got), 64'd1000);
    check("stream_left",  64'(q.size()), 64'd0);
    repeat (6) @(negedge hbus_clk);
    check("stream_end_rempty", 64'(rempty), 64'd1);

    // Read strobe held while empty
    @(negedge hbus_clk);
    rinc = 1'b1;
    repeat (5) @(negedge hbus_clk);
    rinc = 1'b0;
    check("udf_rempty", 64'(rempty), 64'd1);
    write_word(33'h5);
    wait_not_empty("udf_write_visible");
    pop_expect("udf_read_5", 33'h5);
    check("udf_after_pop_rempty", 64'(rempty), 64'd1);
`ifdef ASYNC_FIFO_ERR_EN
    check("sticky_rudf", 64'(rudf), 64'd1);
    check("sticky_wovf", 64'(wovf), 64'd1);
`endif

    // Reset with two entries queued
    write_word(33'h11);
    write_word(33'h22);
    repeat (6) @(negedge hbus_clk);
    check("two_queued_arempty", 64'(arempty), 64'd0);
    #1 hbus_rst = 1'b1;
    #1;
    check("midrst_rempty",  64'(rempty),  64'd1);
    check("midrst_arempty", 64'(arempty), 64'd1);
    check("midrst_wfull",   64'(wfull),   64'd0);
    check("midrst_awfull",  64'(awfull),  64'd0);
`ifdef ASYNC_FIFO_ERR_EN
    check("midrst_wovf", 64'(wovf), 64'd0);
    check("midrst_rudf", 64'(rudf), 64'd0);
`endif
    @(negedge wclk);
    hbus_rst = 1'b0;
    repeat (2) @(negedge wclk);
    write_word(33'h33);
    wait_not_empty("postrst_visible");
    pop_expect("postrst_read", 33'h33);
    check("postrst_rempty", 64'(rempty), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
